// File: rtl/mem_stage_sram_ctrl_if.sv
// SRAM-side bus of the MEM stage: half-word address, split write/read data,
// drive enable for the top-level tristate and active-low write enable.
//   master : the controller (drives address, write data, oe, we_n)
//   slave  : the SRAM / pad wrapper (returns read data)
interface mem_stage_sram_ctrl_if #(
    parameter int SRAM_AW = 18
);
    logic [SRAM_AW-1:0] sram_addr;
    logic [15:0]        sram_dq_out;
    logic               sram_dq_oe;
    logic [15:0]        sram_dq_in;
    logic               sram_we_n;

    modport master (
        output sram_addr,
        output sram_dq_out,
        output sram_dq_oe,
        output sram_we_n,
        input  sram_dq_in
    );

    modport slave (
        input  sram_addr,
        input  sram_dq_out,
        input  sram_dq_oe,
        input  sram_we_n,
        output sram_dq_in
    );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// MEM pipeline stage in front of a 16-bit asynchronous SRAM. Each 32-bit load or
// store is split into a low and a high half-word access, each held for
// WAIT_CYCLES cycles. ready drops for the whole access to freeze upstream
// registers. The stage owns the MEM/WB register.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   wb_en, mem_r_en, mem_w_en      EXE/MEM control
//   alu_result, val_rm, dest       EXE/MEM data (byte address / store data / dest reg)
//   ready                          1 = pipeline may advance
//   sram                           SRAM bus (master side)
//   wb_en_out .. dest_out          MEM/WB register
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no access; a request here starts one (ready low)
// LO     | low half-word access, held WAIT_CYCLES cycles
// HI     | high half-word access, held WAIT_CYCLES cycles
// DONE   | access finished, ready high for one cycle; req not sampled
module mem_stage_sram_ctrl #(
    parameter int ADDR_OFFSET = 1024,
    parameter int SRAM_AW     = 18,
    parameter int WAIT_CYCLES = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wb_en,
    input  logic                        mem_r_en,
    input  logic                        mem_w_en,
    input  logic [31:0]                 alu_result,
    input  logic [31:0]                 val_rm,
    input  logic [3:0]                  dest,
    output logic                        ready,
    mem_stage_sram_ctrl_if.master       sram,
    output logic                        wb_en_out,
    output logic                        mem_r_en_out,
    output logic [31:0]                 alu_result_out,
    output logic [31:0]                 mem_data_out,
    output logic [3:0]                  dest_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int             CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(WAIT_CYCLES - 1);
    localparam logic [31:0]    OFFSET   = 32'(ADDR_OFFSET);
    localparam int             WW       = SRAM_AW - 1;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   rd_lo_q, rd_lo_d;
    logic [15:0]   rd_hi_q, rd_hi_d;

    logic          wb_en_q, wb_en_d;
    logic          mem_r_en_q, mem_r_en_d;
    logic [31:0]   alu_result_q, alu_result_d;
    logic [31:0]   mem_data_q, mem_data_d;
    logic [3:0]    dest_q, dest_d;

    logic          req;
    logic          is_wr;
    logic          cnt_last;
    logic          in_access;
    logic          half;
    logic          borrow;
    logic [WW-1:0] word_idx;

    assign req      = mem_r_en | mem_w_en;
    assign is_wr    = mem_w_en;
    assign cnt_last = (cnt_q == CNT_LAST);

    // Only the word-index bits that reach the SRAM are computed: subtract the
    // offset's word bits and take the borrow out of the byte-lane bits, which is
    // the same as ((alu_result - ADDR_OFFSET) >> 2) truncated.
    assign borrow   = (alu_result[1:0] < OFFSET[1:0]);
    assign word_idx = alu_result[SRAM_AW:2] - OFFSET[SRAM_AW:2] - WW'(borrow);

    assign in_access = (state_q == S_LO) || (state_q == S_HI);
    assign half      = (state_q == S_HI);

    assign ready = ((state_q == S_IDLE) && !req) || (state_q == S_DONE);

    assign sram.sram_addr   = in_access ? {word_idx, half} : '0;
    assign sram.sram_we_n   = !(in_access && is_wr);
    assign sram.sram_dq_oe  = in_access && is_wr;
    assign sram.sram_dq_out = (in_access && is_wr) ? (half ? val_rm[31:16] : val_rm[15:0]) : 16'h0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_lo_d = rd_lo_q;
        rd_hi_d = rd_hi_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_LO;
                    cnt_d   = '0;
                end
            end
            S_LO: begin
                if (cnt_last) begin
                    state_d = S_HI;
                    cnt_d   = '0;
                    if (!is_wr) rd_lo_d = sram.sram_dq_in;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_HI: begin
                if (cnt_last) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    if (!is_wr) rd_hi_d = sram.sram_dq_in;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // MEM/WB: advance with the pipeline, insert a bubble while frozen.
    always_comb begin
        wb_en_d      = 1'b0;
        mem_r_en_d   = 1'b0;
        alu_result_d = alu_result_q;
        mem_data_d   = mem_data_q;
        dest_d       = dest_q;
        if (ready) begin
            wb_en_d      = wb_en;
            mem_r_en_d   = mem_r_en;
            alu_result_d = alu_result;
            mem_data_d   = {rd_hi_q, rd_lo_q};
            dest_d       = dest;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            rd_lo_q      <= '0;
            rd_hi_q      <= '0;
            wb_en_q      <= 1'b0;
            mem_r_en_q   <= 1'b0;
            alu_result_q <= '0;
            mem_data_q   <= '0;
            dest_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_lo_q      <= rd_lo_d;
            rd_hi_q      <= rd_hi_d;
            wb_en_q      <= wb_en_d;
            mem_r_en_q   <= mem_r_en_d;
            alu_result_q <= alu_result_d;
            mem_data_q   <= mem_data_d;
            dest_q       <= dest_d;
        end
    end

    assign wb_en_out      = wb_en_q;
    assign mem_r_en_out   = mem_r_en_q;
    assign alu_result_out = alu_result_q;
    assign mem_data_out   = mem_data_q;
    assign dest_out       = dest_q;

endmodule
